// File: rtl/mdm_dsp_pkg.sv
// Shared DSP encodings for the ADC offset-cut stage: offset mux selections,
// calibration FSM states and signed 16-bit saturation bounds.
package mdm_dsp_pkg;

  typedef enum logic [7:0] {
    OFFSET_MUX_BYPASS = 8'h00,
    OFFSET_MUX_MANUAL = 8'h01,
    OFFSET_MUX_AUTO   = 8'h02
  } offset_mux_e;

  typedef enum logic {
    CAL_IDLE = 1'b0,
    CAL_ACC  = 1'b1
  } cal_state_e;

  localparam logic signed [16:0] SAT16_MAX = 17'sd32767;
  localparam logic signed [16:0] SAT16_MIN = -17'sd32768;

endpackage

// File: rtl/adc_offset_cut_if.sv
// Sample stream into the offset-cut stage and corrected stream out of it.
// master = upstream/consumer side, slave = adc_offset_cut.
interface adc_offset_cut_if #(
  parameter int unsigned WIDTH = 14
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic [15:0]      o_tdata;
  logic             o_tvalid;
  logic             o_above;

  modport master (
    output i_tdata, i_tvalid,
    input  o_tdata, o_tvalid, o_above
  );

  modport slave (
    input  i_tdata, i_tvalid,
    output o_tdata, o_tvalid, o_above
  );
endinterface

// File: rtl/offset_cal_accum.sv
// Averaging calibration: accumulates 2**CAL_LOG2 valid samples after cal_start
// and publishes the truncated mean as auto_offset.
module offset_cal_accum
  import mdm_dsp_pkg::*;
#(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CAL_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cal_start,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             cal_busy,
  output logic             cal_done,
  output logic [15:0]      auto_offset
);

  localparam int unsigned ACC_W = WIDTH + CAL_LOG2;
  localparam int unsigned CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << CAL_LOG2) - 1);

  cal_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] sum;
  logic             last;

  assign sum      = acc_q + ACC_W'(sample);
  assign cal_busy = (state_q == CAL_ACC);

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    case (state_q)
      CAL_IDLE: if (cal_start) state_d = CAL_ACC;
      CAL_ACC: begin
        if (sample_valid && (cnt_q == LAST_CNT)) begin
          last    = 1'b1;
          state_d = CAL_IDLE;
        end
      end
      default: state_d = CAL_IDLE;
    endcase
    // clear dominates both a fresh start and a completing sample
    if (clear) begin
      state_d = CAL_IDLE;
      last    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CAL_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      cal_done    <= 1'b0;
      auto_offset <= '0;
    end else begin
      state_q  <= state_d;
      cal_done <= last;
      if (clear || (state_q == CAL_IDLE) || last) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (sample_valid) begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end
      if (last) auto_offset <= 16'(sum >> CAL_LOG2);
    end
  end

endmodule

// File: rtl/adc_offset_cut.sv
// Subtracts a bypass/manual/auto DC offset from unsigned ADC samples, producing a
// signed 16-bit stream and threshold flag. Define ADC_OFFSET_CUT_SAT_EN to saturate.
module adc_offset_cut
  import mdm_dsp_pkg::*;
#(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CAL_LOG2 = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  adc_offset_cut_if.slave        s,
  input  logic [7:0]             offset_mux,
  input  logic [15:0]            offset_value,
  input  logic [15:0]            threshold_value,
  input  logic                   cal_start,
  output logic                   cal_busy,
  output logic                   cal_done,
  output logic [15:0]            auto_offset
);

  logic [15:0]        sel_offset;
  logic signed [16:0] diff;
  logic [15:0]        res;
  logic [16:0]        mag;
  logic               above;
  logic [15:0]        tdata_q;
  logic               tvalid_q;
  logic               above_q;
  logic               accept;

  offset_cal_accum #(
    .WIDTH    (WIDTH),
    .CAL_LOG2 (CAL_LOG2)
  ) u_cal (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .cal_start    (cal_start),
    .sample       (s.i_tdata),
    .sample_valid (s.i_tvalid),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .auto_offset  (auto_offset)
  );

  always_comb begin
    sel_offset = '0;
    case (offset_mux)
      OFFSET_MUX_MANUAL: sel_offset = offset_value;
      OFFSET_MUX_AUTO:   sel_offset = auto_offset;
      default:           sel_offset = '0;
    endcase
  end

  assign diff = $signed({1'b0, 16'(s.i_tdata)}) - $signed({1'b0, sel_offset});

  always_comb begin
`ifdef ADC_OFFSET_CUT_SAT_EN
    if (diff > SAT16_MAX)      res = 16'(SAT16_MAX);
    else if (diff < SAT16_MIN) res = 16'(SAT16_MIN);
    else                       res = 16'(diff);
`else
    res = 16'(diff);
`endif
  end

  // 17-bit magnitude so that -32768 maps to +32768
  assign mag    = res[15] ? (17'd0 - {1'b1, res}) : {1'b0, res};
  assign above  = (mag > {1'b0, threshold_value});
  assign accept = s.i_tvalid & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      above_q  <= 1'b0;
    end else begin
      tvalid_q <= accept;
      if (accept) begin
        tdata_q <= res;
        above_q <= above;
      end
    end
  end

  assign s.o_tdata  = tdata_q;
  assign s.o_tvalid = tvalid_q;
  assign s.o_above  = above_q & tvalid_q;

endmodule

// File: tb/tb_adc_offset_cut.sv
// Directed self-checking bench for adc_offset_cut (WIDTH=14, CAL_LOG2=6).
module tb_adc_offset_cut;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  offset_mux;
  logic [15:0] offset_value;
  logic [15:0] threshold_value;
  logic        cal_start;
  logic        cal_busy;
  logic        cal_done;
  logic [15:0] auto_offset;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned done_cnt = 0;

  adc_offset_cut_if #(.WIDTH(14)) bus ();

  adc_offset_cut #(
    .WIDTH    (14),
    .CAL_LOG2 (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .s               (bus.slave),
    .offset_mux      (offset_mux),
    .offset_value    (offset_value),
    .threshold_value (threshold_value),
    .cal_start       (cal_start),
    .cal_busy        (cal_busy),
    .cal_done        (cal_done),
    .auto_offset     (auto_offset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (cal_done) done_cnt++;
  endtask

  task automatic send(input logic [13:0] d, input int unsigned gap);
    bus.i_tdata  = d;
    bus.i_tvalid = 1'b1;
    step();
    bus.i_tvalid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    total++;
    if (bus.o_tdata !== 16'h0000 || bus.o_tvalid !== 1'b0 || bus.o_above !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: tdata=%h tvalid=%b above=%b required 0000/0/0", bus.o_tdata, bus.o_tvalid, bus.o_above);
    end
    total++;
    if (cal_busy !== 1'b0 || cal_done !== 1'b0 || auto_offset !== 16'h0000) begin
      bad++;
      $display("FAIL reset_cal: busy=%b done=%b auto=%h required 0/0/0000", cal_busy, cal_done, auto_offset);
    end
  endtask

  task automatic test_bypass();
    offset_mux = 8'h00; offset_value = 16'h2000; threshold_value = 16'hFFFF;
    send(14'h1234, 0);
    total++;
    if (bus.o_tdata !== 16'h1234 || bus.o_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL bypass: tdata=%h tvalid=%b required 1234/1", bus.o_tdata, bus.o_tvalid);
    end
    step();
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tdata !== 16'h1234) begin
      bad++;
      $display("FAIL bypass_hold: tdata=%h tvalid=%b required 1234/0", bus.o_tdata, bus.o_tvalid);
    end
    offset_mux = 8'h07;
    send(14'h0100, 0);
    total++;
    if (bus.o_tdata !== 16'h0100) begin
      bad++;
      $display("FAIL mux_other: tdata=%h required 0100", bus.o_tdata);
    end
  endtask

  task automatic test_manual();
    offset_mux = 8'h01; offset_value = 16'h2000; threshold_value = 16'd4095;
    send(14'h1000, 0);
    total++;
    if (bus.o_tdata !== 16'hF000 || bus.o_above !== 1'b1) begin
      bad++;
      $display("FAIL manual_thr4095: tdata=%h above=%b required F000/1", bus.o_tdata, bus.o_above);
    end
    threshold_value = 16'd4096;
    send(14'h1000, 0);
    total++;
    if (bus.o_tdata !== 16'hF000 || bus.o_above !== 1'b0) begin
      bad++;
      $display("FAIL manual_thr4096: tdata=%h above=%b required F000/0", bus.o_tdata, bus.o_above);
    end
    offset_value = 16'h0010; threshold_value = 16'd15;
    send(14'h0020, 0);
    total++;
    if (bus.o_tdata !== 16'h0010 || bus.o_above !== 1'b1) begin
      bad++;
      $display("FAIL manual_pos: tdata=%h above=%b required 0010/1", bus.o_tdata, bus.o_above);
    end
    step();
    total++;
    if (bus.o_above !== 1'b0) begin
      bad++;
      $display("FAIL above_qual: above=%b required 0", bus.o_above);
    end
  endtask

  task automatic test_saturation();
    offset_mux = 8'h01; offset_value = 16'hFFFF; threshold_value = 16'd32767;
    send(14'h0000, 0);
    total++;
`ifdef ADC_OFFSET_CUT_SAT_EN
    if (bus.o_tdata !== 16'h8000 || bus.o_above !== 1'b1) begin
      bad++;
      $display("FAIL saturate: tdata=%h above=%b required 8000/1", bus.o_tdata, bus.o_above);
    end
`else
    if (bus.o_tdata !== 16'h0001 || bus.o_above !== 1'b0) begin
      bad++;
      $display("FAIL wrap: tdata=%h above=%b required 0001/0", bus.o_tdata, bus.o_above);
    end
`endif
    offset_value = 16'h8000;
    send(14'h0000, 0);
    total++;
    if (bus.o_tdata !== 16'h8000 || bus.o_above !== 1'b1) begin
      bad++;
      $display("FAIL min_mag: tdata=%h above=%b required 8000/1", bus.o_tdata, bus.o_above);
    end
  endtask

  task automatic test_clear_valid();
    clear = 1'b1;
    send(14'h0055, 0);
    clear = 1'b0;
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tdata !== 16'h8000) begin
      bad++;
      $display("FAIL clear_valid: tvalid=%b tdata=%h required 0/8000", bus.o_tvalid, bus.o_tdata);
    end
  endtask

  task automatic test_calibration();
    done_cnt = 0;
    offset_mux = 8'h00;
    cal_start = 1'b1;
    send(14'h3FFF, 0);
    cal_start = 1'b0;
    total++;
    if (cal_busy !== 1'b1) begin
      bad++;
      $display("FAIL cal_busy: busy=%b required 1", cal_busy);
    end
    for (int i = 0; i < 64; i++) send(14'h1F40, 0);
    total++;
    if (auto_offset !== 16'h1F40 || cal_done !== 1'b1 || cal_busy !== 1'b0) begin
      bad++;
      $display("FAIL cal_result: auto=%h done=%b busy=%b required 1F40/1/0", auto_offset, cal_done, cal_busy);
    end
    repeat (3) step();
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL cal_done_once: pulses=%0d required 1", done_cnt);
    end
    offset_mux = 8'h02;
    send(14'h1F40, 0);
    total++;
    if (bus.o_tdata !== 16'h0000) begin
      bad++;
      $display("FAIL auto_apply: tdata=%h required 0000", bus.o_tdata);
    end
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    offset_mux = 8'h02;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    send(14'd100, $urandom_range(0, 2));
    total++;
    if (bus.o_tdata !== 16'hE124) begin
      bad++;
      $display("FAIL old_auto_in_acc: tdata=%h required E124", bus.o_tdata);
    end
    for (int i = 1; i < 32; i++) send(14'd100, $urandom_range(0, 2));
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    for (int i = 0; i < 31; i++) send(14'd101, $urandom_range(0, 2));
    send(14'd101, 0);
    total++;
    if (auto_offset !== 16'd100 || cal_done !== 1'b1) begin
      bad++;
      $display("FAIL truncate: auto=%0d done=%b required 100/1", auto_offset, cal_done);
    end
    send(14'd100, 2);
    total++;
    if (done_cnt !== 1 || cal_busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_ignored: pulses=%0d busy=%b required 1/0", done_cnt, cal_busy);
    end
    total++;
    if (bus.o_tdata !== 16'h0000) begin
      bad++;
      $display("FAIL new_auto_apply: tdata=%h required 0000", bus.o_tdata);
    end
  endtask

  task automatic test_abort();
    done_cnt = 0;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    for (int i = 0; i < 30; i++) send(14'h3000, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 40; i++) send(14'h3000, 0);
    total++;
    if (cal_busy !== 1'b0 || done_cnt !== 0 || auto_offset !== 16'd100) begin
      bad++;
      $display("FAIL abort_clear: busy=%b pulses=%0d auto=%0d required 0/0/100", cal_busy, done_cnt, auto_offset);
    end
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    for (int i = 0; i < 30; i++) send(14'h3000, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (auto_offset !== 16'h0000 || cal_busy !== 1'b0 || bus.o_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL abort_rst: auto=%h busy=%b tvalid=%b required 0000/0/0", auto_offset, cal_busy, bus.o_tvalid);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; cal_start = 1'b0;
    offset_mux = 8'h00; offset_value = 16'h0000; threshold_value = 16'hFFFF;
    bus.i_tdata = '0; bus.i_tvalid = 1'b0;
    test_reset();
    test_bypass();
    test_manual();
    test_saturation();
    test_clear_valid();
    test_calibration();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
